dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core load/store path and the return-address-stack spill/fill engine.
- Sits between the core/RAS request signals and the memory controller port.
- Sequences each transaction and enforces fixed read latency.
- Provides per-requester acknowledge and stall signals, and alternates grants on conflict so neither requester starves.

Parameters:
- RD_LAT, 1, memory read latency in cycles from mem_en to valid mem_dout (legal range 1..7)
- AW, 32, address width

Ports:
- clk  in  1  system clock
- Rst  in  1  asynchronous active-high reset
- core_req  in  1  core transaction request (level, held until core_ack)
- core_we  in  1  1 = write, 0 = read
- core_be  in  4  byte enables
- core_addr  in  AW  byte address
- core_wdata  in  32  write data
- core_rdata  out  32  read data, valid only when core_ack=1
- core_ack  out  1  one-cycle completion pulse
- core_hold  out  1  core_req & ~core_ack (combinational stall)
- ras_rd  in  1  RAS fill request (level)
- ras_wr  in  1  RAS spill request (level)
- ras_addr  in  AW  word address; bits [1:0] forced to 0
- ras_wdata  in  32  spill data
- ras_rdata  out  32  fill data, valid only when ras_ack=1
- ras_ack  out  1  one-cycle completion pulse
- ras_rdy  out  1  1 when the FSM is IDLE and no RAS transaction is pending
- mem_en  out  1  memory command strobe (registered)
- mem_we  out  1  memory write (registered)
- mem_be  out  4  byte enables; 4'hF for RAS (registered)
- mem_addr  out  AW  memory address (registered)
- mem_din  out  32  memory write data (registered)
- mem_dout  in  32  memory read data
- proto_err  out  1  sticky flag, set when ras_rd and ras_wr are both high; cleared only by Rst

Behaviour:
- Reset (asynchronous, Rst=1):
  - state=IDLE; all outputs 0 except ras_rdy=1.
  - last_grant=CORE, so RAS wins the first conflict.
  - Any in-flight transaction is dropped; no ack is issued for it.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: sample requests at the clock edge.
  - Only one requester active: grant it.
  - Both active: grant the requester opposite to last_grant, then update last_grant.
  - On grant: latch command into mem_* registers → ISSUE.
- ISSUE (1 cycle, mem_en=1):
  - Write → ACK.
  - Read with RD_LAT=1 → ACK.
  - Read with RD_LAT>1 → WAIT; load lat_cnt=RD_LAT-1.
- WAIT: mem_en=0; decrement lat_cnt; when lat_cnt==1 → ACK.
- ACK (1 cycle):
  - Assert ack of the granted requester.
  - For reads, drive its rdata = mem_dout; the other rdata holds 0.
  - → IDLE.
- mem_en is 0 in IDLE, WAIT and ACK.
- Latency from request seen in IDLE to ack:
  - write: 2 cycles
  - read: RD_LAT+1 cycles
- One IDLE bubble between transactions. Maximum throughput is one transaction per 3 cycles.
- RAS command encoding:
  - ras_wr=1 → write.
  - ras_rd=1 → read.
  - Both high → treated as write, proto_err set.
- Requesters must hold address and data stable until ack. Inputs are sampled only in IDLE; later changes are ignored.
- Requester deasserting before ack: the transaction still completes and the ack pulse is still issued. A new request the cycle after ack is arbitrated normally.
- A request that stays high in the ACK cycle is treated as a new request at the following IDLE.
- core_hold is combinational (core_req & ~core_ack). It must not depend on mem_dout.
- core_rdata and ras_rdata are 0 whenever their ack is 0.

Test Plan:
- Reset, then core write: core_we=1, be=4'b0011, addr=0x100, wdata=0xDEADBEEF → next cycle mem_en=1, mem_we=1, mem_be=4'b0011, mem_addr=0x100; core_ack 2 cycles after request; core_hold=1 for 2 cycles.
- RD_LAT=3, core read of 0x200 with memory returning 0xCAFEF00D → mem_en high for exactly 1 cycle; core_ack with core_rdata=0xCAFEF00D 4 cycles after request.
- Simultaneous core_req and ras_wr held continuously for 4 transactions → grants alternate RAS, CORE, RAS, CORE; RAS mem_be=4'hF; ras_addr=0x1003 appears as mem_addr=0x1000.
- ras_rd and ras_wr both high → write issued; proto_err=1 and remains 1 until Rst.
- Rst asserted during WAIT (RD_LAT=3) → outputs 0 immediately; no ack pulse; the next conflict grants RAS first.
- core_req dropped in the ISSUE cycle → core_ack still pulses once; no second transaction is issued.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-way arbiter sharing one data-memory port between the core load/store
// path and the RAS spill/fill engine, with fixed read latency sequencing.
module dmem_port_arbiter #(
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [3:0]    core_be,
  input  logic [AW-1:0] core_addr,
  input  logic [31:0]   core_wdata,
  output logic [31:0]   core_rdata,
  output logic          core_ack,
  output logic          core_hold,
  input  logic          ras_rd,
  input  logic          ras_wr,
  input  logic [AW-1:0] ras_addr,
  input  logic [31:0]   ras_wdata,
  output logic [31:0]   ras_rdata,
  output logic          ras_ack,
  output logic          ras_rdy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout,
  output logic          proto_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  logic [1:0] state;
  logic [2:0] lat_cnt;
  logic       grant_ras;
  logic       last_grant_ras;
  logic       ras_any;
  logic       conflict;
  logic       pick_ras;

  // On conflict the requester that did not win last time is served.
  always_comb begin
    ras_any  = ras_rd | ras_wr;
    conflict = ras_any & core_req;
    pick_ras = ras_any & (~core_req | ~last_grant_ras);
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state          <= S_IDLE;
      lat_cnt        <= 3'd0;
      grant_ras      <= 1'b0;
      last_grant_ras <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_be         <= 4'h0;
      mem_addr       <= '0;
      mem_din        <= 32'h0;
      proto_err      <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      if (ras_rd & ras_wr)
        proto_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (core_req | ras_any) begin
            state     <= S_ISSUE;
            mem_en    <= 1'b1;
            grant_ras <= pick_ras;
            if (conflict)
              last_grant_ras <= pick_ras;
            if (pick_ras) begin
              mem_we   <= ras_wr;
              mem_be   <= 4'hF;
              mem_addr <= ras_addr & ~AW'(3);
              mem_din  <= ras_wdata;
            end else begin
              mem_we   <= core_we;
              mem_be   <= core_be;
              mem_addr <= core_addr;
              mem_din  <= core_wdata;
            end
          end
        end
        S_ISSUE: begin
          if (mem_we || RD_LAT == 1) begin
            state <= S_ACK;
          end else begin
            state   <= S_WAIT;
            lat_cnt <= LAT_LOAD;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1)
            state <= S_ACK;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data is only passed through during the owner's ack cycle.
  always_comb begin
    core_ack   = (state == S_ACK) & ~grant_ras;
    ras_ack    = (state == S_ACK) & grant_ras;
    core_rdata = (core_ack & ~mem_we) ? mem_dout : 32'h0;
    ras_rdata  = (ras_ack & ~mem_we) ? mem_dout : 32'h0;
    core_hold  = core_req & ~core_ack;
    ras_rdy    = (state == S_IDLE);
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter built with a 3-cycle read latency.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        Rst;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_ack, core_hold;
  logic        ras_rd, ras_wr;
  logic [31:0] ras_addr, ras_wdata, ras_rdata;
  logic        ras_ack, ras_rdy;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        proto_err;

  int compared = 0;
  int mismatched = 0;

  dmem_port_arbiter #(.RD_LAT(3), .AW(32)) dut (
    .clk(clk), .Rst(Rst),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_ack(core_ack), .core_hold(core_hold),
    .ras_rd(ras_rd), .ras_wr(ras_wr), .ras_addr(ras_addr),
    .ras_wdata(ras_wdata), .ras_rdata(ras_rdata), .ras_ack(ras_ack),
    .ras_rdy(ras_rdy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic creq, input logic cwe, input logic [3:0] cbe,
                               input logic [31:0] caddr, input logic [31:0] cwdata,
                               input logic rrd, input logic rwr,
                               input logic [31:0] raddr, input logic [31:0] rwdata);
    core_req   = creq;
    core_we    = cwe;
    core_be    = cbe;
    core_addr  = caddr;
    core_wdata = cwdata;
    ras_rd     = rrd;
    ras_wr     = rwr;
    ras_addr   = raddr;
    ras_wdata  = rwdata;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    bit exp_ras;
    Rst = 1'b1;
    mem_dout = 32'h0;
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_ras_rdy", 32'(ras_rdy), 32'd1);
    checkOutput("rst_core_ack", 32'(core_ack), 32'd0);
    checkOutput("rst_proto_err", 32'(proto_err), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    Rst = 1'b0;
    tick;

    // core write
    applyStimulus(1, 1, 4'b0011, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
    #1 checkOutput("wr_hold_idle", 32'(core_hold), 32'd1);
    tick;
    checkOutput("wr_mem_en", 32'(mem_en), 32'd1);
    checkOutput("wr_mem_we", 32'(mem_we), 32'd1);
    checkOutput("wr_mem_be", 32'(mem_be), 32'h3);
    checkOutput("wr_mem_addr", mem_addr, 32'h100);
    checkOutput("wr_mem_din", mem_din, 32'hDEADBEEF);
    checkOutput("wr_hold_issue", 32'(core_hold), 32'd1);
    checkOutput("wr_ras_rdy", 32'(ras_rdy), 32'd0);
    tick;
    checkOutput("wr_ack", 32'(core_ack), 32'd1);
    checkOutput("wr_hold_ack", 32'(core_hold), 32'd0);
    checkOutput("wr_mem_en_ack", 32'(mem_en), 32'd0);
    checkOutput("wr_rdata_zero", core_rdata, 32'h0);
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    tick;
    checkOutput("wr_ack_gone", 32'(core_ack), 32'd0);
    checkOutput("wr_idle_rdy", 32'(ras_rdy), 32'd1);

    // core read, 3-cycle latency
    mem_dout = 32'hCAFEF00D;
    applyStimulus(1, 0, 4'hF, 32'h200, 0, 0, 0, 0, 0);
    tick;
    checkOutput("rd_mem_en", 32'(mem_en), 32'd1);
    checkOutput("rd_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rd_mem_addr", mem_addr, 32'h200);
    tick;
    checkOutput("rd_wait1_en", 32'(mem_en), 32'd0);
    checkOutput("rd_wait1_ack", 32'(core_ack), 32'd0);
    checkOutput("rd_wait1_rdata", core_rdata, 32'h0);
    tick;
    checkOutput("rd_wait2_ack", 32'(core_ack), 32'd0);
    checkOutput("rd_wait2_en", 32'(mem_en), 32'd0);
    tick;
    checkOutput("rd_ack", 32'(core_ack), 32'd1);
    checkOutput("rd_rdata", core_rdata, 32'hCAFEF00D);
    checkOutput("rd_ras_rdata", ras_rdata, 32'h0);
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    tick;
    checkOutput("rd_ack_gone", 32'(core_ack), 32'd0);

    // continuous conflict: RAS, CORE, RAS, CORE
    applyStimulus(1, 1, 4'b1100, 32'h300, 32'h11111111, 0, 1, 32'h1003, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      exp_ras = (i % 2 == 0);
      tick;
      checkOutput($sformatf("cf%0d_mem_en", i), 32'(mem_en), 32'd1);
      checkOutput($sformatf("cf%0d_mem_addr", i), mem_addr, exp_ras ? 32'h1000 : 32'h300);
      checkOutput($sformatf("cf%0d_mem_be", i), 32'(mem_be), exp_ras ? 32'hF : 32'hC);
      checkOutput($sformatf("cf%0d_mem_din", i), mem_din, exp_ras ? 32'h22222222 : 32'h11111111);
      checkOutput($sformatf("cf%0d_hold", i), 32'(core_hold), 32'd1);
      tick;
      checkOutput($sformatf("cf%0d_ras_ack", i), 32'(ras_ack), 32'(exp_ras));
      checkOutput($sformatf("cf%0d_core_ack", i), 32'(core_ack), 32'(!exp_ras));
      if (i == 3) applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      tick;
      checkOutput($sformatf("cf%0d_idle_en", i), 32'(mem_en), 32'd0);
    end

    // ras_rd and ras_wr together: write plus sticky error
    applyStimulus(0, 0, 4'h0, 0, 0, 1, 1, 32'h2000, 32'h33333333);
    tick;
    checkOutput("pe_mem_we", 32'(mem_we), 32'd1);
    checkOutput("pe_mem_be", 32'(mem_be), 32'hF);
    checkOutput("pe_mem_din", mem_din, 32'h33333333);
    checkOutput("pe_flag", 32'(proto_err), 32'd1);
    tick;
    checkOutput("pe_ras_ack", 32'(ras_ack), 32'd1);
    checkOutput("pe_ras_rdata", ras_rdata, 32'h0);
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    tick; tick; tick;
    checkOutput("pe_sticky", 32'(proto_err), 32'd1);

    // reset during WAIT with last grant left at RAS
    mem_dout = 32'h5A5A1234;
    applyStimulus(1, 0, 4'hF, 32'h500, 0, 1, 0, 32'h44, 0);
    tick;
    checkOutput("rw_first_ras", mem_addr, 32'h44);
    tick;
    Rst = 1'b1;
    #1;
    checkOutput("rw_rst_en", 32'(mem_en), 32'd0);
    checkOutput("rw_rst_addr", mem_addr, 32'h0);
    checkOutput("rw_rst_rdy", 32'(ras_rdy), 32'd1);
    checkOutput("rw_rst_perr", 32'(proto_err), 32'd0);
    tick;
    checkOutput("rw_no_ras_ack", 32'(ras_ack), 32'd0);
    checkOutput("rw_no_core_ack", 32'(core_ack), 32'd0);
    Rst = 1'b0;
    tick;
    checkOutput("rw_regrant_ras", mem_addr, 32'h44);
    checkOutput("rw_regrant_en", 32'(mem_en), 32'd1);
    tick; tick;
    checkOutput("rw_wait_ack", 32'(ras_ack), 32'd0);
    tick;
    checkOutput("rw_ras_ack", 32'(ras_ack), 32'd1);
    checkOutput("rw_ras_rdata", ras_rdata, 32'h5A5A1234);
    checkOutput("rw_core_rdata", core_rdata, 32'h0);
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    tick;

    // core_req dropped during ISSUE
    applyStimulus(1, 1, 4'hF, 32'h600, 32'h66666666, 0, 0, 0, 0);
    tick;
    checkOutput("dr_mem_en", 32'(mem_en), 32'd1);
    core_req = 1'b0;
    #1 checkOutput("dr_hold", 32'(core_hold), 32'd0);
    tick;
    checkOutput("dr_ack", 32'(core_ack), 32'd1);
    tick;
    checkOutput("dr_ack_once", 32'(core_ack), 32'd0);
    checkOutput("dr_idle_en", 32'(mem_en), 32'd0);
    tick;
    checkOutput("dr_no_reissue", 32'(mem_en), 32'd0);
    checkOutput("dr_rdy", 32'(ras_rdy), 32'd1);
    checkOutput("dr_no_ack", 32'(core_ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
